// File: rtl/booth_seq_pkg.sv
// booth_seq_pkg: shared constants and helpers for the booth window sequencer.
`default_nettype none

package booth_seq_pkg;

  localparam int WIN_STRIDE = 3;
  localparam int WIN_SIZE   = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One window per 3 operand bits, rounded up.
  function automatic int calc_nwin(input int width);
    return (width + 2) / WIN_STRIDE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: steps overlapping 4-bit windows of an operand through an
// external booth recoder and packs the returned 3-bit codes into one word.
`default_nettype none

module booth_seq_ctrl
  import booth_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NWIN  = calc_nwin(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      op_i,
  output logic [3:0]            win_o,
  output logic                  win_valid,
  input  logic [2:0]            c_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*NWIN-1:0]     codes_o,
  input  logic                  flush
);

  localparam int SW   = WIN_STRIDE * NWIN;
  localparam int EXTW = SW + 1;
  localparam int CW   = $clog2(NWIN);

  logic [1:0]      state;
  logic [EXTW-1:0] ext;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   codes;
  logic [SW-1:0]   op_sext;
  logic [3:0]      win_sel;
  logic            last_win;

  assign op_sext  = SW'(signed'(op_i));
  assign last_win = (cnt == CW'(NWIN - 1));

  always_comb begin
    win_sel = '0;
    for (int i = 0; i < NWIN; i++) begin
      if (cnt == CW'(i)) begin
        win_sel = ext[WIN_STRIDE*i +: WIN_SIZE];
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign win_valid = (state == S_RUN);
  assign out_valid = (state == S_DONE);
  assign win_o     = (state == S_RUN) ? win_sel : 4'd0;
  assign codes_o   = codes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ext   <= '0;
      cnt   <= '0;
      codes <= '0;
    end else if (flush) begin
      // Abort wins over any handshake offered in the same cycle.
      state <= S_IDLE;
      cnt   <= '0;
      codes <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            ext   <= {op_sext, 1'b0};
            cnt   <= '0;
            codes <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NWIN; i++) begin
            if (cnt == CW'(i)) begin
              codes[WIN_STRIDE*i +: 3] <= c_i;
            end
          end
          if (last_win) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: randomized and directed checks of the booth sequencer
// against an arithmetic window/recoder model.
`default_nettype none

module tb_booth_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int NWIN  = (WIDTH + 2) / 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  op_i;
  logic [3:0]        win_o;
  logic              win_valid;
  logic [2:0]        c_i;
  logic              out_valid;
  logic              out_ready;
  logic [3*NWIN-1:0] codes_o;
  logic              flush;
  logic [2:0]        junk;

  int checks = 0;
  int errors = 0;

  booth_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_i(op_i), .win_o(win_o), .win_valid(win_valid), .c_i(c_i),
    .out_valid(out_valid), .out_ready(out_ready), .codes_o(codes_o),
    .flush(flush)
  );

  always #5 clk = ~clk;

  // Radix-8 booth digit -4*b3 + 2*b2 + b1 + b0, kept as 3 low bits.
  function automatic logic [2:0] booth_f(input logic [3:0] w);
    int d;
    d = -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    return 3'(d & 7);
  endfunction

  // Recoder stand-in; garbage when the sequencer should ignore it.
  assign c_i = win_valid ? booth_f(win_o) : junk;
  always @(negedge clk) junk <= 3'($urandom);

  function automatic logic [3:0] exp_win(input logic [WIDTH-1:0] op, input int i);
    longint e;
    e = longint'(signed'(op)) * 2;
    return 4'((e >>> (3 * i)) & 15);
  endfunction

  function automatic logic [3*NWIN-1:0] exp_codes(input logic [WIDTH-1:0] op);
    logic [3*NWIN-1:0] r;
    r = '0;
    for (int i = 0; i < NWIN; i++) r[3*i +: 3] = booth_f(exp_win(op, i));
    return r;
  endfunction

  // Called and returns at a negedge with the DUT idle.
  task automatic run_op(input logic [WIDTH-1:0] op, input int hold);
    logic [3*NWIN-1:0] ec;
    ec = exp_codes(op);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready op=%h got=%b want=1", op, in_ready);
    end
    op_i = op; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < NWIN; k++) begin
      checks++;
      if (win_valid !== 1'b1 || win_o !== exp_win(op, k) || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL run_win op=%h k=%0d got win=%b wv=%b ir=%b ov=%b want win=%b wv=1 ir=0 ov=0",
                 op, k, win_o, win_valid, in_ready, out_valid, exp_win(op, k));
      end
      in_valid = 1'($urandom_range(0, 1));
      op_i = WIDTH'($urandom);
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || codes_o !== ec || win_valid !== 1'b0 || win_o !== 4'd0) begin
      errors++;
      $display("FAIL done_out op=%h got ov=%b codes=%h wv=%b win=%b want ov=1 codes=%h wv=0 win=0",
               op, out_valid, codes_o, win_valid, win_o, ec);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || codes_o !== ec || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold op=%h h=%0d got ov=%b codes=%h ir=%b want ov=1 codes=%h ir=0",
                 op, h, out_valid, codes_o, in_ready, ec);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake op=%h got ir=%b ov=%b wv=%b want ir=1 ov=0 wv=0",
               op, in_ready, out_valid, win_valid);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (in_ready !== 1'b1 || win_valid !== 1'b0 || out_valid !== 1'b0 ||
        win_o !== 4'd0 || codes_o !== '0) begin
      errors++;
      $display("FAIL %s got ir=%b wv=%b ov=%b win=%b codes=%h want ir=1 wv=0 ov=0 win=0 codes=0",
               tag, in_ready, win_valid, out_valid, win_o, codes_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op_i = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset_idle");
  endtask

  task automatic test_directed();
    run_op(16'h0001, 0);
    run_op(16'hFFFF, 1);
    run_op(16'h8000, 2);
    run_op(16'h0003, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) run_op(WIDTH'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_backpressure();
    run_op(16'h5A3C, 20);
  endtask

  task automatic test_flush();
    op_i = 16'h7B21; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1; in_valid = 1'b1; op_i = 16'h1234;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check_reset_vals("flush_run");
    run_op(16'hC0DE, 0);
    // Flush while a result is waiting.
    op_i = 16'h4321; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (NWIN) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check_reset_vals("flush_done");
  endtask

  task automatic test_async_reset();
    op_i = 16'h5A5A; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h0003, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
